control: RTL and testbench

Main control decoder for the 32-bit single-cycle (non-pipelined) MIPS datapath. It takes the 6-bit opcode field (instruction[31:26]) and drives the datapath steering signals: register-file destination and write enable, memory read/write, ALU operand source, ALU operation class, write-back mux, branch and jump. Outputs follow the opcode combinationally within a cycle. A synchronously sampled active-low reset forces every output to the inactive (all-zero) state.

---
 rtl/control_pkg.sv | 35 +++
 rtl/control_main_decoder.sv | 52 +++++
 rtl/control.sv | 56 +++++
 tb/tb_control.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared opcode, ALUOp and control-word definitions for the MIPS main control decoder.
package control_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 2;

  // Opcode field values (instruction[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // ALU operation class handed to the ALU control unit
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // Full set of datapath steering fields produced per opcode
  typedef struct packed {
    logic               reg_dst;
    logic               branch;
    logic               jump;
    logic               mem_read;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic               branch_test;
  } ctrl_t;

endpackage : control_pkg

// File: rtl/control_main_decoder.sv
// Purely combinational opcode-to-control-word decode; unknown opcodes decode to an all-zero NOP.
module control_main_decoder
  import control_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o
);

  // Opcode decode; everything not set for an opcode stays at the zero default
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch      = 1'b1;
        ctrl_o.branch_test = 1'b1;
        ctrl_o.alu_op      = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_o.branch      = 1'b1;
        ctrl_o.branch_test = 1'b0;
        ctrl_o.alu_op      = ALUOP_SUB;
      end
      OP_J: begin
        ctrl_o.jump = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule : control_main_decoder

// File: rtl/control.sv
// MIPS single-cycle main control: zero-latency opcode decode gated by a sampled active-low reset.
module control
  import control_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] instruction,
  output logic                RegDst,
  output logic                Branch,
  output logic                Jump,
  output logic                MemRead,
  output logic                MemtoReg,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                MemWrite,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                BranchTest
);

  logic  rst_q;
  logic  rst_d;
  ctrl_t dec_c;
  ctrl_t gated_c;

  control_main_decoder u_main_decoder (
    .opcode_i (instruction),
    .ctrl_o   (dec_c)
  );

  assign rst_d = ~reset;

  // Reset is only honoured once sampled on a rising edge
  always_ff @(posedge clk) begin
    rst_q <= rst_d;
  end

  // Force every steering signal inactive while the sampled reset is held
  always_comb begin
    gated_c = '0;
    if (!rst_q) begin
      gated_c = dec_c;
    end
  end

  assign RegDst     = gated_c.reg_dst;
  assign Branch     = gated_c.branch;
  assign Jump       = gated_c.jump;
  assign MemRead    = gated_c.mem_read;
  assign MemtoReg   = gated_c.mem_to_reg;
  assign ALUOp      = gated_c.alu_op;
  assign MemWrite   = gated_c.mem_write;
  assign ALUSrc     = gated_c.alu_src;
  assign RegWrite   = gated_c.reg_write;
  assign BranchTest = gated_c.branch_test;

endmodule : control

// File: tb/tb_control.sv
// Directed bench for control: hand-computed control words per opcode plus reset timing cases.
module tb_control;

  logic       clk;
  logic       reset;
  logic [5:0] instruction;
  logic       RegDst, Branch, Jump, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, BranchTest;
  logic [1:0] ALUOp;
  logic [10:0] outs;

  int n_vec;
  int n_err;

  // Word order: RegDst Branch Jump MemRead MemtoReg ALUOp[1:0] MemWrite ALUSrc RegWrite BranchTest
  localparam logic [10:0] W_ZERO = 11'b0_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] W_R    = 11'b1_0_0_0_0_10_0_0_1_0;
  localparam logic [10:0] W_LW   = 11'b0_0_0_1_1_00_0_1_1_0;
  localparam logic [10:0] W_SW   = 11'b0_0_0_0_0_00_1_1_0_0;
  localparam logic [10:0] W_BEQ  = 11'b0_1_0_0_0_01_0_0_0_1;
  localparam logic [10:0] W_BNE  = 11'b0_1_0_0_0_01_0_0_0_0;
  localparam logic [10:0] W_J    = 11'b0_0_1_0_0_00_0_0_0_0;
  localparam logic [10:0] W_ADDI = 11'b0_0_0_0_0_00_0_1_1_0;

  control dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .RegDst      (RegDst),
    .Branch      (Branch),
    .Jump        (Jump),
    .MemRead     (MemRead),
    .MemtoReg    (MemtoReg),
    .ALUOp       (ALUOp),
    .MemWrite    (MemWrite),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .BranchTest  (BranchTest)
  );

  assign outs = {RegDst, Branch, Jump, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, BranchTest};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run-time guard so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: run still active at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Change the opcode mid-cycle and let the combinational decode settle
  task automatic set_op(input logic [5:0] op);
    @(negedge clk);
    instruction = op;
    #1;
  endtask

  // Step past the next rising edge and sample shortly after
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    instruction = 6'b000000;

    // Reset held low for two edges
    edge_step();
    edge_step();
    check_eq("reset_rtype", outs, W_ZERO);

    // Release between edges: still gated until sampled
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("release_presample", outs, W_ZERO);
    edge_step();
    check_eq("rtype_after_release", outs, W_R);

    set_op(6'b100011); check_eq("lw", outs, W_LW);
    set_op(6'b101011); check_eq("sw", outs, W_SW);
    set_op(6'b000100); check_eq("beq", outs, W_BEQ);
    set_op(6'b000101); check_eq("bne", outs, W_BNE);
    set_op(6'b000010); check_eq("j", outs, W_J);
    set_op(6'b001000); check_eq("addi", outs, W_ADDI);
    set_op(6'b111111); check_eq("undef_111111", outs, W_ZERO);
    set_op(6'b001111); check_eq("undef_001111", outs, W_ZERO);
    set_op(6'b000000); check_eq("rtype", outs, W_R);

    // Low pulse entirely between edges is never sampled
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    edge_step();
    check_eq("unsampled_pulse", outs, W_R);

    // lw held while reset is asserted mid-run
    set_op(6'b100011);
    check_eq("lw_before_reset", outs, W_LW);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("reset_presample", outs, W_LW);
    edge_step();
    check_eq("reset_entry", outs, W_ZERO);
    edge_step();
    check_eq("reset_hold", outs, W_ZERO);

    // Opcode change during reset stays invisible
    set_op(6'b000010);
    check_eq("op_change_in_reset", outs, W_ZERO);
    set_op(6'b100011);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("exit_presample", outs, W_ZERO);
    edge_step();
    check_eq("lw_after_exit", outs, W_LW);

    // Sweep all opcodes: defined ones by table, all others must be NOP; invariants on each
    for (int op = 0; op < 64; op++) begin
      logic [10:0] exp;
      logic [5:0]  opv;
      opv = 6'(op);
      case (opv)
        6'b000000: exp = W_R;
        6'b100011: exp = W_LW;
        6'b101011: exp = W_SW;
        6'b000100: exp = W_BEQ;
        6'b000101: exp = W_BNE;
        6'b000010: exp = W_J;
        6'b001000: exp = W_ADDI;
        default:   exp = W_ZERO;
      endcase
      set_op(opv);
      check_eq($sformatf("sweep_%b", opv), outs, exp);
      check_eq($sformatf("inv_%b", opv),
               {8'b0, ~(MemRead & MemWrite), ~(Jump & (RegWrite | MemWrite)), ~(BranchTest & ~Branch)},
               11'b000_0000_0111);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_control
